// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush initiator for the 5-stage MiniMIPS32 pipeline.
// Raises the stall bus and flush line that the PC and the inter-stage
// registers consume. Outstanding data accesses are tracked by a small wait
// FSM with a timeout, and the redirect PC for exceptions and ERET is chosen
// here as well. The stall, flush, flush_pc and bus_err outputs are
// combinational from the inputs and the state. The state, the wait counter
// and the stall-cycle counter are registers.
module pipeline_ctrl #(
  parameter int          DWAIT_TIMEOUT = 255,
  parameter int          CNT_W         = 8,
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,       // active-high asynchronous reset
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_exe,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  input  logic        exc_req,
  input  logic        exc_eret,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        bus_err,
  output logic [31:0] perf_stall_cnt
);

  // Each stall pattern freezes the requesting stage and everything behind it.
  // The pattern also inserts a bubble into the stage ahead of the requester.
  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_PC    = 6'b000001;
  localparam logic [5:0] STALL_IF    = 6'b000011;
  localparam logic [5:0] STALL_ID    = 6'b000111;
  localparam logic [5:0] STALL_EXE   = 6'b001111;
  localparam logic [5:0] STALL_MEM   = 6'b011111;

  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(DWAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [CNT_W-1:0] wait_cnt_next;
  logic [31:0]      perf_cnt_reg;

  logic [5:0]       lower_stall;
  logic [31:0]      exc_target;
  logic [5:0]       stall_next;
  logic             flush_next;
  logic [31:0]      flush_pc_next;
  logic             bus_err_next;

  // Pick the highest-priority stall request among EXE, ID and IF.
  // The patterns are selected one at a time and are never combined.
  always_comb begin
    lower_stall = STALL_NONE;
    if (stallreq_exe) begin
      lower_stall = STALL_EXE;
    end else if (stallreq_id) begin
      lower_stall = STALL_ID;
    end else if (stallreq_if) begin
      lower_stall = STALL_IF;
    end
  end

  // ERET returns to EPC. Every other exception goes to the fixed vector.
  always_comb begin
    exc_target = exc_eret ? cp0_epc : EXC_VECTOR;
  end

  // Decide the outputs and the next FSM state for the current cycle.
  always_comb begin
    stall_next    = STALL_NONE;
    flush_next    = 1'b0;
    flush_pc_next = EXC_VECTOR;
    bus_err_next  = 1'b0;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;

    unique case (state_reg)
      RUN: begin
        if (exc_req) begin
          // A flush overrides every stall request.
          // A data access issued in the same cycle is dropped with its instruction.
          flush_next    = 1'b1;
          flush_pc_next = exc_target;
        end else if (dmem_req && !dmem_ack) begin
          stall_next    = STALL_MEM;
          state_next    = DWAIT;
          wait_cnt_next = CNT_ONE;
        end else begin
          // The access either completed with no wait state or none was issued.
          stall_next = lower_stall;
        end
      end

      DWAIT: begin
        if (dmem_ack) begin
          // The access completes, so the MEM stall is released in this same cycle.
          state_next    = RUN;
          wait_cnt_next = '0;
          if (exc_req) begin
            flush_next    = 1'b1;
            flush_pc_next = exc_target;
          end else begin
            stall_next = lower_stall;
          end
        end else if (wait_cnt_reg == CNT_TIMEOUT) begin
          // The memory is not responding, so a bus error is raised.
          // The pipeline is flushed and the late ack is absorbed in DRAIN.
          flush_next    = 1'b1;
          bus_err_next  = 1'b1;
          flush_pc_next = EXC_VECTOR;
          state_next    = DRAIN;
          wait_cnt_next = '0;
        end else begin
          // An exception from MEM is ignored while its access is still outstanding.
          stall_next    = STALL_MEM;
          wait_cnt_next = wait_cnt_reg + CNT_ONE;
        end
      end

      DRAIN: begin
        // The pipeline is empty, so only the PC has to be held until the orphaned ack arrives.
        if (dmem_ack) begin
          state_next = RUN;
        end else begin
          stall_next = STALL_PC;
        end
      end

      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // The outputs are forced to their idle values while reset is held.
  always_comb begin
    if (cpu_rst_n) begin
      stall    = STALL_NONE;
      flush    = 1'b0;
      flush_pc = EXC_VECTOR;
      bus_err  = 1'b0;
    end else begin
      stall    = stall_next;
      flush    = flush_next;
      flush_pc = flush_pc_next;
      bus_err  = bus_err_next;
    end
  end

  // Register the FSM state and the wait counter. Reset returns to RUN immediately.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst_n) begin
    if (cpu_rst_n) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Count every cycle in which the PC is held. The counter wraps naturally at 2^32.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst_n) begin
    if (cpu_rst_n) begin
      perf_cnt_reg <= '0;
    end else if (stall[0]) begin
      perf_cnt_reg <= perf_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scoreboard bench for pipeline_ctrl (DWAIT_TIMEOUT = 4).
// Each step drives one cycle of inputs and queues the expected outputs.
// It then pops that entry and compares it against the DUT away from the clock edge.
module tb_pipeline_ctrl;

  localparam logic [31:0] EV = 32'hBFC00380;

  // control word bits: {rst, eret, exc, ack, req, exe, id, if}
  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_IF   = 8'h01;
  localparam logic [7:0] C_ID   = 8'h02;
  localparam logic [7:0] C_EXE  = 8'h04;
  localparam logic [7:0] C_REQ  = 8'h08;
  localparam logic [7:0] C_ACK  = 8'h10;
  localparam logic [7:0] C_EXC  = 8'h20;
  localparam logic [7:0] C_ERET = 8'h40;
  localparam logic [7:0] C_RST  = 8'h80;

  localparam logic [5:0] S_0   = 6'b000000;
  localparam logic [5:0] S_PC  = 6'b000001;
  localparam logic [5:0] S_IF  = 6'b000011;
  localparam logic [5:0] S_ID  = 6'b000111;
  localparam logic [5:0] S_EXE = 6'b001111;
  localparam logic [5:0] S_MEM = 6'b011111;

  logic        clk = 1'b0;
  logic        rst, sif, sid, sexe, req, ack, exc, eret;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        bus_err;
  logic [31:0] perf_stall_cnt;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        chk_pc;
    logic        berr;
    logic [31:0] perf;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_perf = 32'd0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .DWAIT_TIMEOUT(4),
    .CNT_W(8),
    .EXC_VECTOR(EV)
  ) dut (
    .cpu_clk_50M   (clk),
    .cpu_rst_n     (rst),
    .stallreq_if   (sif),
    .stallreq_id   (sid),
    .stallreq_exe  (sexe),
    .dmem_req      (req),
    .dmem_ack      (ack),
    .exc_req       (exc),
    .exc_eret      (eret),
    .cp0_epc       (epc),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .bus_err       (bus_err),
    .perf_stall_cnt(perf_stall_cnt)
  );

  task automatic step(input logic [7:0] c, input logic [31:0] epc_in,
                      input logic [5:0] es, input logic ef, input logic [31:0] ep,
                      input logic eb, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    {rst, eret, exc, ack, req, sexe, sid, sif} = c;
    epc = epc_in;
    if (c[7]) exp_perf = 32'd0;
    e.stall  = es;
    e.flush  = ef;
    e.pc     = ep;
    e.chk_pc = ef | c[7];
    e.berr   = eb;
    e.perf   = exp_perf;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    checks++;
    assert (stall === got.stall) else begin
      errors++;
      $error("FAIL %s stall observed=%b expected=%b", tag, stall, got.stall);
    end
    checks++;
    assert (flush === got.flush) else begin
      errors++;
      $error("FAIL %s flush observed=%b expected=%b", tag, flush, got.flush);
    end
    checks++;
    assert (bus_err === got.berr) else begin
      errors++;
      $error("FAIL %s bus_err observed=%b expected=%b", tag, bus_err, got.berr);
    end
    checks++;
    assert (perf_stall_cnt === got.perf) else begin
      errors++;
      $error("FAIL %s perf observed=%0d expected=%0d", tag, perf_stall_cnt, got.perf);
    end
    if (got.chk_pc) begin
      checks++;
      assert (flush_pc === got.pc) else begin
        errors++;
        $error("FAIL %s flush_pc observed=%h expected=%h", tag, flush_pc, got.pc);
      end
    end
    $display("step %-12s stall=%b flush=%b pc=%h berr=%b perf=%0d",
             tag, stall, flush, flush_pc, bus_err, perf_stall_cnt);
    if (got.stall[0]) exp_perf = exp_perf + 32'd1;
  endtask

  initial begin
    {rst, eret, exc, ack, req, sexe, sid, sif} = C_RST;
    epc = 32'd0;

    // reset held 3 cycles, with active requests that must stay masked
    step(C_RST,                      32'h0,        S_0, 1'b0, EV, 1'b0, "rst0");
    step(C_RST | C_EXE | C_REQ,      32'h0,        S_0, 1'b0, EV, 1'b0, "rst1");
    step(C_RST | C_EXC | C_ERET,     32'h12345678, S_0, 1'b0, EV, 1'b0, "rst2");

    // lower-stage priority
    step(C_ID | C_EXE,               32'h0, S_EXE, 1'b0, EV, 1'b0, "id_exe");
    step(C_IF,                       32'h0, S_IF,  1'b0, EV, 1'b0, "if_only");
    step(C_IF | C_ID,                32'h0, S_ID,  1'b0, EV, 1'b0, "if_id");
    step(C_NONE,                     32'h0, S_0,   1'b0, EV, 1'b0, "idle");

    // MEM wait with ack 3 cycles later; MEM beats EXE and IF
    step(C_REQ | C_EXE | C_IF,       32'h0, S_MEM, 1'b0, EV, 1'b0, "mem_w0");
    step(C_NONE,                     32'h0, S_MEM, 1'b0, EV, 1'b0, "mem_w1");
    step(C_NONE,                     32'h0, S_MEM, 1'b0, EV, 1'b0, "mem_w2");
    step(C_ACK,                      32'h0, S_0,   1'b0, EV, 1'b0, "mem_ack");
    step(C_REQ | C_ACK | C_IF,       32'h0, S_IF,  1'b0, EV, 1'b0, "zero_wait");

    // timeout: 4 MEM stall cycles, then a bus-error flush that ignores exc/eret
    step(C_REQ,                      32'h0, S_MEM, 1'b0, EV, 1'b0, "to_w0");
    step(C_NONE,                     32'h0, S_MEM, 1'b0, EV, 1'b0, "to_w1");
    step(C_NONE,                     32'h0, S_MEM, 1'b0, EV, 1'b0, "to_w2");
    step(C_NONE,                     32'h0, S_MEM, 1'b0, EV, 1'b0, "to_w3");
    step(C_EXC | C_ERET,             32'h12345678, S_0, 1'b1, EV, 1'b1, "timeout");
    step(C_EXE,                      32'h0, S_PC,  1'b0, EV, 1'b0, "drain0");
    step(C_EXC,                      32'h0, S_PC,  1'b0, EV, 1'b0, "drain_exc");
    step(C_ACK,                      32'h0, S_0,   1'b0, EV, 1'b0, "drain_ack");
    step(C_REQ | C_ACK,              32'h0, S_0,   1'b0, EV, 1'b0, "run_again");

    // DWAIT: exc without ack is ignored; exc with ack flushes
    step(C_REQ,                      32'h0, S_MEM, 1'b0, EV, 1'b0, "dw_req");
    step(C_EXC | C_ERET,             32'h55550000, S_MEM, 1'b0, EV, 1'b0, "dw_exc_ign");
    step(C_ACK | C_EXC,              32'h0, S_0,   1'b1, EV, 1'b0, "dw_ack_exc");

    // ERET while EXE is busy: flush wins, target is EPC
    step(C_EXE | C_EXC | C_ERET,     32'h80001000, S_0, 1'b1, 32'h80001000, 1'b0, "eret");
    step(C_EXC | C_REQ,              32'h0, S_0,   1'b1, EV, 1'b0, "exc_req_drop");
    step(C_NONE,                     32'h0, S_0,   1'b0, EV, 1'b0, "post_exc");

    // reset in the 2nd DWAIT cycle
    step(C_REQ,                      32'h0, S_MEM, 1'b0, EV, 1'b0, "r6_req");
    step(C_NONE,                     32'h0, S_MEM, 1'b0, EV, 1'b0, "r6_dw1");
    step(C_RST,                      32'h0, S_0,   1'b0, EV, 1'b0, "r6_rst");
    step(C_RST,                      32'h0, S_0,   1'b0, EV, 1'b0, "r6_rst2");
    step(C_NONE,                     32'h0, S_0,   1'b0, EV, 1'b0, "r6_run");
    step(C_REQ,                      32'h0, S_MEM, 1'b0, EV, 1'b0, "r6_w0");
    step(C_NONE,                     32'h0, S_MEM, 1'b0, EV, 1'b0, "r6_w1");
    step(C_NONE,                     32'h0, S_MEM, 1'b0, EV, 1'b0, "r6_w2");
    step(C_NONE,                     32'h0, S_MEM, 1'b0, EV, 1'b0, "r6_w3");
    step(C_NONE,                     32'h0, S_0,   1'b1, EV, 1'b1, "r6_timeout");
    step(C_ACK,                      32'h0, S_0,   1'b0, EV, 1'b0, "r6_drain_ack");
    step(C_IF,                       32'h0, S_IF,  1'b0, EV, 1'b0, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
